// File: rtl/nf_board_pkg.sv
// nf_board_pkg: board-level constants and types shared by the input conditioning path.
//   NF_CLK_HZ           system clock frequency
//   NF_DB_TICK_DIV      clk cycles per debounce filter tick (1 kHz)
//   NF_DB_STABLE_TICKS  consecutive ticks of mismatch before a new level is accepted
//   nf_db_ch_t          per-channel debounced level plus its edge pulses
package nf_board_pkg;

    localparam int unsigned NF_CLK_HZ          = 50_000_000;
    localparam int unsigned NF_DB_TICK_DIV     = NF_CLK_HZ / 1000;
    localparam int unsigned NF_DB_STABLE_TICKS = 10;

    typedef struct packed {
        logic lvl;
        logic rise;
        logic fall;
    } nf_db_ch_t;

endpackage

// File: rtl/nf_debounce_ch.sv
// nf_debounce_ch: one debounce channel (2-FF synchroniser, polarity fix, tick-based filter).
//   clk     system clock
//   rst     asynchronous reset, active-high
//   raw     asynchronous pin level
//   tick    shared filter tick from the prescaler
//   ch      debounced logical level with registered rise/fall pulses
//   accept  combinational: a new level is accepted at the next clock edge
module nf_debounce_ch
    import nf_board_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = NF_DB_STABLE_TICKS,
    parameter logic        INV          = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      raw,
    input  logic      tick,
    output nf_db_ch_t ch,
    output logic      accept
);

    localparam int unsigned CW = $clog2(STABLE_TICKS + 1);

    logic [1:0]    sync;
    logic          s;
    logic [CW-1:0] cnt;
    logic          lvl;
    logic          rise;
    logic          fall;

    // Sync stages reset to the idle physical level so the logical level starts at 0.
    assign s = sync[1] ^ INV;

    always_comb begin
        accept = (s != lvl) && tick && (cnt == CW'(STABLE_TICKS - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= {INV, INV};
            cnt  <= '0;
            lvl  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            rise <= accept & s;
            fall <= accept & ~s;
            // Agreement clears progress before a tick is considered.
            if (s == lvl) begin
                cnt <= '0;
            end else if (tick) begin
                if (accept) begin
                    lvl <= s;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign ch = '{lvl: lvl, rise: rise, fall: fall};

endmodule

// File: rtl/nf_debounce.sv
// nf_debounce: conditions raw board inputs (keys, switches) into clean levels and pulses.
//   clk     system clock
//   rst     asynchronous reset, active-high
//   raw_in  asynchronous pin levels
//   db_out  debounced logical level per channel
//   rise    one-cycle pulse, channel went 0->1 (logical)
//   fall    one-cycle pulse, channel went 1->0 (logical)
//   chg     one-cycle pulse, any rise or fall in the same cycle
module nf_debounce
    import nf_board_pkg::*;
#(
    parameter int unsigned      WIDTH        = 12,
    parameter int unsigned      TICK_DIV     = NF_DB_TICK_DIV,
    parameter int unsigned      STABLE_TICKS = NF_DB_STABLE_TICKS,
    parameter logic [WIDTH-1:0] INV_MASK     = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             chg
);

    localparam int unsigned PW = $clog2(TICK_DIV);

    logic [PW-1:0]    pcnt;
    logic             tick;
    logic [WIDTH-1:0] accept;
    nf_db_ch_t        chs [WIDTH];

    assign tick = (pcnt == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        nf_debounce_ch #(
            .STABLE_TICKS (STABLE_TICKS),
            .INV          (INV_MASK[i])
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .raw    (raw_in[i]),
            .tick   (tick),
            .ch     (chs[i]),
            .accept (accept[i])
        );
        assign db_out[i] = chs[i].lvl;
        assign rise[i]   = chs[i].rise;
        assign fall[i]   = chs[i].fall;
    end

    // Registered from the same accept terms as rise/fall, so it lines up with them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chg <= 1'b0;
        end else begin
            chg <= |accept;
        end
    end

endmodule

// File: tb/tb_nf_debounce.sv
module tb_nf_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] raw_in = 4'b0011;
    logic [3:0] db_out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       chg;

    nf_debounce #(
        .WIDTH        (4),
        .TICK_DIV     (4),
        .STABLE_TICKS (3),
        .INV_MASK     (4'b0011)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .raw_in (raw_in),
        .db_out (db_out),
        .rise   (rise),
        .fall   (fall),
        .chg    (chg)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] raw;
        int         cycles;
        logic [3:0] db;
        logic [3:0] rise;
        logic [3:0] fall;
        int         chg;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] rise_acc = '0;
    logic [3:0] fall_acc = '0;
    logic [3:0] prev_db  = '0;
    int         chg_cnt  = 0;
    vec_t       vecs [8];
    vec_t       sb [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s: got %0d cycles expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    // Per-cycle pulse consistency: pulses must coincide with a level change and last one cycle.
    always @(negedge clk) begin
        if (!rst) begin
            rise_acc = rise_acc | rise;
            fall_acc = fall_acc | fall;
            if (chg) chg_cnt++;
            check("chg_is_or", {31'd0, chg}, {31'd0, |(rise | fall)});
            check("rise_align", {28'd0, rise}, {28'd0, db_out & ~prev_db});
            check("fall_align", {28'd0, fall}, {28'd0, ~db_out & prev_db});
        end
        prev_db = db_out;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic clear_acc();
        rise_acc = '0;
        fall_acc = '0;
        chg_cnt  = 0;
    endtask

    task automatic drain_and_compare();
        vec_t e;
        e = sb.pop_front();
        check({e.name, "_db"},   {28'd0, db_out},   {28'd0, e.db});
        check({e.name, "_rise"}, {28'd0, rise_acc}, {28'd0, e.rise});
        check({e.name, "_fall"}, {28'd0, fall_acc}, {28'd0, e.fall});
        check({e.name, "_chg"},  chg_cnt,           e.chg);
    endtask

    task automatic apply(input vec_t v);
        clear_acc();
        raw_in = v.raw;
        sb.push_back(v);
        wait_cyc(v.cycles);
        drain_and_compare();
    endtask

    // Cycles from now until the chosen bit of db_out (sel_rise=0) or rise (sel_rise=1) goes high.
    task automatic wait_bit(input logic sel_rise, input int ch, output int n);
        logic [3:0] v;
        n = 0;
        v = sel_rise ? rise : db_out;
        while (!v[ch] && n < 40) begin
            wait_cyc(1);
            n++;
            v = sel_rise ? rise : db_out;
        end
    endtask

    initial begin
        int   n;
        vec_t g;

        vecs[0] = '{"reset_idle",  4'b0011, 100, 4'b0000, 4'b0000, 4'b0000, 0};
        vecs[1] = '{"ch0_press",   4'b0110, 20,  4'b0101, 4'b0001, 4'b0000, 1};
        vecs[2] = '{"ch0_release", 4'b0111, 20,  4'b0100, 4'b0000, 4'b0001, 1};
        vecs[3] = '{"ch2_release", 4'b0011, 20,  4'b0000, 4'b0000, 4'b0100, 1};
        vecs[4] = '{"ch1_press",   4'b0001, 20,  4'b0010, 4'b0010, 4'b0000, 1};
        vecs[5] = '{"ch1_release", 4'b0011, 20,  4'b0000, 4'b0000, 4'b0010, 1};
        vecs[6] = '{"ch23_press",  4'b1111, 20,  4'b1100, 4'b1100, 4'b0000, 1};
        vecs[7] = '{"ch23_rel",    4'b0011, 20,  4'b0000, 4'b0000, 4'b1100, 1};

        // Reset with idle pins held, then confirm quiet outputs.
        raw_in = 4'b0011;
        rst    = 1'b1;
        wait_cyc(3);
        check("reset_db", {28'd0, db_out}, 32'd0);
        check("reset_pulses", {27'd0, rise, fall, chg}, 32'd0);
        rst = 1'b0;
        apply(vecs[0]);

        // ch2 press: latency window and a single rise/chg.
        clear_acc();
        raw_in = 4'b0111;
        sb.push_back('{"ch2_press", 4'b0111, 0, 4'b0100, 4'b0100, 4'b0000, 1});
        wait_bit(1'b0, 2, n);
        check_range("ch2_latency", n, 11, 15);
        wait_cyc(10);
        drain_and_compare();

        for (int i = 1; i < 8; i++) begin
            apply(vecs[i]);
        end

        // Glitch rejection on ch3: 6-cycle highs never survive three ticks.
        clear_acc();
        g = '{"ch3_glitch", 4'b0011, 0, 4'b0000, 4'b0000, 4'b0000, 0};
        sb.push_back(g);
        for (int r = 0; r < 5; r++) begin
            raw_in = 4'b1011;
            wait_cyc(6);
            raw_in = 4'b0011;
            wait_cyc(6);
        end
        wait_cyc(20);
        drain_and_compare();

        // Reset mid-filter on ch2, then full-latency re-acceptance.
        clear_acc();
        raw_in = 4'b0111;
        wait_cyc(8);
        rst = 1'b1;
        wait_cyc(2);
        check("midrst_db", {28'd0, db_out}, 32'd0);
        check("midrst_pulses", {27'd0, rise, fall, chg}, 32'd0);
        rst = 1'b0;
        clear_acc();
        sb.push_back('{"post_rst", 4'b0111, 0, 4'b0100, 4'b0100, 4'b0000, 1});
        wait_bit(1'b1, 2, n);
        check_range("post_rst_latency", n, 11, 15);
        wait_cyc(10);
        drain_and_compare();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
